// File: rtl/sar_search.sv
// sar_search: successive-approximation search driving a magnitude comparator, MSB first
module sar_search #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             aGreaterB,
  input  logic             aEqualB,
  input  logic             aLessB,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic {IDLE, SEARCH} state_t;
  state_t state, nextState;
  logic [IW-1:0] idx, idxNext;
  logic [WIDTH-1:0] prefix, prefixNext, trialNext, resultNext, step;
  logic doneNext, errNext, oneHot, lastBit, finish;
  assign oneHot = $onehot({aGreaterB, aEqualB, aLessB});
  assign lastBit = idx == '0;
  assign finish = !oneHot || aEqualB || lastBit;
  assign step = (WIDTH'(1) << idx) >> 1;
  assign busy = state == SEARCH;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nextState;
  // next state: leave IDLE on start, leave SEARCH on any terminating comparison
  always_comb
    nextState = (state == IDLE) ? (start ? SEARCH : IDLE) : (finish ? IDLE : SEARCH);
  // next datapath values; a greater flag keeps the trial bit, a less flag drops it
  always_comb begin
    trialNext = '0;
    prefixNext = prefix;
    idxNext = idx;
    resultNext = result;
    doneNext = 1'b0;
    errNext = 1'b0;
    if (state == IDLE && start) begin
      trialNext = {1'b1, {(WIDTH-1){1'b0}}};
      idxNext = IW'(WIDTH-1);
      prefixNext = '0;
    end else if (state == SEARCH && finish) begin
      doneNext = 1'b1;
      errNext = !oneHot || aGreaterB;
      resultNext = (!oneHot || aGreaterB) ? '0 : (aEqualB ? trial : prefix);
    end else if (state == SEARCH) begin
      idxNext = idx - 1'b1;
      prefixNext = aGreaterB ? trial : prefix;
      trialNext = (aGreaterB ? trial : prefix) | step;
    end
  end
  // datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      trial <= '0;
      prefix <= '0;
      idx <= '0;
      result <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      trial <= trialNext;
      prefix <= prefixNext;
      idx <= idxNext;
      result <= resultNext;
      done <= doneNext;
      err <= errNext;
    end
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: scoreboard bench for sar_search with a behavioural comparator and fault injection
module tb_sar_search;
  typedef struct {logic [7:0] res; logic err; int k;} exp_t;
  logic clk = 0, rst = 1, start = 0;
  logic aGreaterB, aEqualB, aLessB, busy, done, err;
  logic [7:0] trial, result, target = 0, faultTrial = 0;
  logic faultOn = 0;
  int faultKind = 0;
  int tests = 0, fails = 0, busyCnt = 0;
  exp_t q[$];
  logic faulty;
  sar_search #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .start(start), .aGreaterB(aGreaterB),
    .aEqualB(aEqualB), .aLessB(aLessB), .trial(trial), .busy(busy), .done(done), .err(err),
    .result(result));
  // comparator model; fault kinds: 0 greater+less, 1 greater only, 2 no flag
  assign faulty = faultOn && trial == faultTrial;
  assign aGreaterB = faulty ? (faultKind != 2) : (target > trial);
  assign aEqualB = faulty ? 1'b0 : (target == trial);
  assign aLessB = faulty ? (faultKind == 0) : (target < trial);
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int expK(input logic [7:0] t);
    for (int i = 0; i < 8; i++) if (t[i]) return 8 - i;
    return 8;
  endfunction
  // caller sits on a negedge; returns on the next negedge with start released
  task automatic launch(input logic [7:0] t, input logic [7:0] r, input logic e, input int k);
    exp_t x;
    x.res = r;
    x.err = e;
    x.k = k;
    target = t;
    q.push_back(x);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic waitDone();
    for (int n = 0; n < 40; n++) begin
      if (done) return;
      @(negedge clk);
    end
    chk("doneTimeout", 1, 0);
  endtask
  // monitor: count busy cycles, compare each completion against the scoreboard head
  always @(negedge clk) begin
    exp_t x;
    if (rst) busyCnt = 0;
    else begin
      if (busy) busyCnt++;
      if (done) begin
        if (q.size() == 0) chk("unexpectedDone", 1, 0);
        else begin
          x = q.pop_front();
          chk("result", int'(result), int'(x.res));
          chk("err", int'(err), int'(x.err));
          chk("latency", busyCnt, x.k);
          chk("busyAtDone", int'(busy), 0);
          chk("trialAtDone", int'(trial), 0);
        end
        busyCnt = 0;
      end else if (err) chk("errWithoutDone", 1, 0);
    end
  end
  initial begin
    logic [7:0] seq255 [8] = '{128, 192, 224, 240, 248, 252, 254, 255};
    logic [7:0] seq0 [8] = '{128, 64, 32, 16, 8, 4, 2, 1};
    #12;
    chk("rstTrial", int'(trial), 0);
    chk("rstBusy", int'(busy), 0);
    chk("rstDone", int'(done), 0);
    chk("rstErr", int'(err), 0);
    chk("rstResult", int'(result), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    launch(128, 128, 0, 1);
    chk("firstTrial", int'(trial), 128);
    chk("busyRise", int'(busy), 1);
    waitDone();
    @(negedge clk);
    launch(0, 0, 0, 8);
    for (int i = 0; i < 8; i++) begin
      chk("seq0", int'(trial), int'(seq0[i]));
      @(negedge clk);
    end
    waitDone();
    @(negedge clk);
    launch(255, 255, 0, 8);
    for (int i = 0; i < 8; i++) begin
      chk("seq255", int'(trial), int'(seq255[i]));
      @(negedge clk);
    end
    waitDone();
    launch(77, 77, 0, 8);
    waitDone();
    launch(96, 96, 0, 3);
    waitDone();
    launch(1, 1, 0, 8);
    waitDone();
    faultOn = 1;
    faultKind = 0;
    faultTrial = 32;
    launch(0, 0, 1, 3);
    waitDone();
    faultKind = 1;
    faultTrial = 1;
    launch(0, 0, 1, 8);
    waitDone();
    faultKind = 2;
    faultTrial = 128;
    launch(100, 0, 1, 1);
    waitDone();
    faultOn = 0;
    launch(200, 200, 0, 5);
    waitDone();
    @(negedge clk);
    target = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    chk("midRstTrial", int'(trial), 0);
    chk("midRstBusy", int'(busy), 0);
    chk("midRstDone", int'(done), 0);
    chk("midRstErr", int'(err), 0);
    chk("midRstResult", int'(result), 0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    launch(77, 77, 0, 8);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    waitDone();
    for (int t = 0; t < 256; t++) begin
      launch(8'(t), 8'(t), 0, expK(8'(t)));
      waitDone();
    end
    repeat (3) @(negedge clk);
    chk("queueDrained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller that drives the trial (`b`) operand of the team's `comparator` and consumes its three result flags to find an unknown `WIDTH`-bit value presented on the comparator's `a` input. It resolves one bit per clock, MSB first, and terminates early on equality. It sits on the opposite side of the comparator interface from whatever produces the target value. Typical users are threshold/calibration loops that can only observe a target through a magnitude comparison.

## Interface
- `WIDTH`, default 8: width of the trial and result values; must be >= 2.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a new search; sampled only in IDLE.
- `aGreaterB`  input  1  comparator flag: target > `trial`.
- `aEqualB`  input  1  comparator flag: target == `trial`.
- `aLessB`  input  1  comparator flag: target < `trial`.
- `trial`  output  WIDTH  registered value driven to the comparator `b` input.
- `busy`  output  1  high while in SEARCH.
- `done`  output  1  one-cycle pulse marking search completion (success or error).
- `err`  output  1  one-cycle pulse coincident with `done` when the flags were inconsistent.
- `result`  output  WIDTH  found value; held until the next completion.

## Operation
- States: IDLE and SEARCH. Internal bit index `idx` (log2 WIDTH bits) and kept-prefix register.
- Reset (async, immediate): state IDLE, `trial`=0, `busy`=0, `done`=0, `err`=0, `result`=0, `idx`=0, prefix=0.
- IDLE: `trial`=0, `busy`=0. When `start`=1 at an edge, the block sets `trial`=1<<(WIDTH-1), `idx`=WIDTH-1, prefix=0, `busy`=1, and moves to SEARCH.
- SEARCH: the comparator is combinational, so the flags for the current `trial` are sampled at every edge. Invariant: the target lies in [prefix, prefix + 2^(idx+1) - 1], and `trial` = prefix | (1<<idx). At each edge, exactly one of the following applies:
  - Flags not one-hot (none set, or more than one set): `result`=0, `err` pulse, `done` pulse, go to IDLE.
  - `aEqualB`: `result`=`trial`, `done` pulse, go to IDLE.
  - `aGreaterB` with `idx`=0: impossible for a correct comparator, so the block raises an `err` pulse, sets `result`=0, pulses `done`, and goes to IDLE.
  - `aLessB` with `idx`=0: `result`=prefix, `done` pulse, go to IDLE.
  - `aGreaterB` with `idx`>0: prefix=`trial`, `idx`-1, `trial`=`trial` | (1<<(idx-1)).
  - `aLessB` with `idx`>0: prefix unchanged, `idx`-1, `trial`=prefix | (1<<(idx-1)).
- `start` in SEARCH is ignored; no queuing.
- On every exit from SEARCH, `trial` returns to 0 and `busy` drops on the same edge that raises `done`.
- `done`/`err` are cleared on the following edge unconditionally.
- Arithmetic: bit-set/OR only; no adders, no wrap-around possible.

## Timing
- `start` sampled at edge N → `busy`=1, `trial`=MSB-only visible after edge N.
- Number of comparisons k is between 1 and WIDTH; `done`, `result`, and `busy`=0 are visible after edge N+k.
- Worst case is WIDTH+1 edges from `start` to `done`; best case (target = 2^(WIDTH-1)) is 2 edges.
- Back-to-back: `start` high while `done` is high is accepted (state is already IDLE), so a new search begins at the next edge with no dead cycle.
- `rst` mid-search: outputs go to reset values immediately, no `done` pulse, previous `result` is lost (0).
- Flags must be stable within the cycle after `trial` changes; the block adds no input registering.

## Test plan
- Target 128, WIDTH=8, `start` pulse → 1 comparison; `done`=1, `result`=128, `err`=0, 2 edges after `start`.
- Target 0 → `trial` sequence 128,64,32,16,8,4,2,1, all `aLessB`; `done` after edge N+8, `result`=0, `err`=0.
- Target 255 → `trial` 128,192,224,240,248,252,254,255; `aEqualB` at 255; `result`=255 after edge N+8.
- Target 77 via real `comparator` instance → `result`=77; sweep all 256 targets with exact latency check.
- Fault injection: force `aGreaterB`=`aLessB`=1 on the 3rd comparison → `err`=`done`=1, `result`=0, `busy`=0; force `aGreaterB` at `idx`=0 → `err`.
- Assert `rst` on the 4th SEARCH cycle → all outputs 0 immediately, no `done`. Then `start` during `busy` is ignored, and `start` coincident with `done` launches a new search.
